dwc_cmd_arb: RTL and testbench
==============================

Name: dwc_cmd_arb

Overview:
- Round-robin arbiter that shares one input-side width-converter command path among NUM_REQ processor command FIFOs.
- A grant is held for exactly CMD_WORD_NUMBER accepted beats, so the downstream packer never mixes words from different requesters.
- Sits between the per-requester command FIFOs and the width-converter's fifo_cmd_* input.

Parameters:
- NUM_REQ, 4, number of requesting command FIFOs (2..16).
- INPUT_DATA_WIDTH, 32, width of one command word.
- OUTPUT_DATA_WIDTH, 128, width of the packed command downstream.
- CMD_WORD_NUMBER, OUTPUT_DATA_WIDTH/INPUT_DATA_WIDTH, beats per command (>=1).
- STALL_LIMIT, 255, idle cycles allowed mid-command before stall_err is flagged.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  NUM_REQ  per-requester word valid.
- req_ready  output  NUM_REQ  per-requester word accepted (only the granted bit can be 1).
- req_wdata  input  NUM_REQ*INPUT_DATA_WIDTH  requester i data at slice [i*IW +: IW].
- arb_cmd_valid  output  1  muxed valid to the width converter.
- arb_cmd_ready  input  1  width-converter ready.
- arb_cmd_wdata  output  INPUT_DATA_WIDTH  muxed word.
- grant_id  output  $clog2(NUM_REQ)  current owner; valid while busy=1.
- busy  output  1  a grant is held.
- cmd_done  output  1  one-cycle pulse after the last beat of a command is accepted.
- stall_err  output  1  sticky; set on stall overrun, cleared only by reset.

Behaviour:
- Reset: while rst_n=0 at a clk edge, the following are forced:
  - state=IDLE, rr_ptr=0, beat_cnt=0, stall_cnt=0, grant_id=0
  - busy=0, cmd_done=0, stall_err=0
  - arb_cmd_valid=0, req_ready=0
  - reset asserted mid-command drops the grant with no completion pulse.
- State machine: IDLE, LOCK.
- IDLE:
  - Outputs arb_cmd_valid=0 and req_ready=0.
  - If any req_valid is set, the winner is the first set bit searching from rr_ptr upward with wrap (index rr_ptr has highest priority).
  - Next cycle: grant_id=winner, busy=1, state=LOCK, beat_cnt=0.
  - Arbitration latency is 1 cycle, and no word is transferred in the arbitration cycle.
- LOCK (combinational pass-through, zero added latency):
  - arb_cmd_valid = req_valid[grant_id]
  - arb_cmd_wdata = req_wdata slice grant_id
  - req_ready[grant_id] = arb_cmd_ready; all other req_ready bits are 0.
  - Handshake = arb_cmd_valid & arb_cmd_ready.
  - On a handshake with beat_cnt < CMD_WORD_NUMBER-1: beat_cnt increments.
  - On a handshake with beat_cnt == CMD_WORD_NUMBER-1: the next cycle has state=IDLE, busy=0, beat_cnt=0, cmd_done=1, and rr_ptr=(grant_id+1) mod NUM_REQ.
  - CMD_WORD_NUMBER=1: every single-beat handshake completes a command.
  - Valid from other requesters is ignored while locked, even if it has higher priority.
- Back-to-back commands:
  - The minimum gap between commands is 1 cycle (the IDLE arbitration cycle).
  - A requester that just completed has the lowest priority next round.
- Stall watch, in LOCK only:
  - stall_cnt increments each cycle req_valid[grant_id]=0 and saturates at STALL_LIMIT.
  - stall_cnt resets to 0 on any handshake or on leaving LOCK.
  - When stall_cnt reaches STALL_LIMIT, stall_err is set. The grant is NOT released, so command integrity is kept.
- Downstream backpressure (arb_cmd_ready=0 with valid=1) does not count as a stall.
- grant_id and rr_ptr are $clog2(NUM_REQ) wide; wrap uses explicit modulo for non-power-of-2 NUM_REQ.
- beat_cnt is $clog2(CMD_WORD_NUMBER)+1 bits wide.

Test Plan:
- Reset, then req_valid=4'b0100 with arb_cmd_ready=1 held:
  - cycle 1: grant_id=2, busy=1
  - next 4 cycles: words 0xA0..0xA3 pass through
  - following cycle: cmd_done=1, busy=0, rr_ptr=3.
- All four requesters valid continuously with ready=1: grant order is 0,1,2,3,0; each command is 4 beats; exactly 1 idle cycle between commands.
- Backpressure: arb_cmd_ready toggles 1,0,1,0 during requester-1 ownership:
  - only cycles with ready=1 advance beat_cnt
  - req_ready[1] mirrors ready; req_ready for others stays 0
  - the command takes 8 cycles.
- Mid-command preemption attempt: grant on requester 3 after 2 beats, then requester 0 asserts valid. Requester 0 gets no ready until requester 3 completes its 4th beat; then requester 0 is granted.
- Stall, with STALL_LIMIT=4: granted requester drops valid after beat 1 for 6 cycles. stall_err rises on the 4th idle cycle and stays 1; the command then completes normally once valid returns.
- Synchronous reset pulse (rst_n=0 for 1 cycle) after beat 2: next cycle busy=0, beat_cnt=0, no cmd_done, rr_ptr=0; the new arbitration starts from requester 0.

Source files
------------

// File: rtl/dwc_cmd_arb.sv
// Round-robin command arbiter for the width-converter input path.
// A grant is held for exactly CMD_WORD_NUMBER accepted beats so packed words never mix owners.
module dwc_cmd_arb #(
    parameter int unsigned NUM_REQ           = 4,
    parameter int unsigned INPUT_DATA_WIDTH  = 32,
    parameter int unsigned OUTPUT_DATA_WIDTH = 128,
    parameter int unsigned CMD_WORD_NUMBER   = OUTPUT_DATA_WIDTH / INPUT_DATA_WIDTH,
    parameter int unsigned STALL_LIMIT       = 255
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ*INPUT_DATA_WIDTH-1:0]   req_wdata,
    output logic                                  arb_cmd_valid,
    input  logic                                  arb_cmd_ready,
    output logic [INPUT_DATA_WIDTH-1:0]           arb_cmd_wdata,
    output logic [$clog2(NUM_REQ)-1:0]            grant_id,
    output logic                                  busy,
    output logic                                  cmd_done,
    output logic                                  stall_err
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned BCW = $clog2(CMD_WORD_NUMBER) + 1;
    localparam int unsigned SCW = $clog2(STALL_LIMIT + 1);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(CMD_WORD_NUMBER - 1);
    localparam logic [SCW-1:0] STALL_MAX = SCW'(STALL_LIMIT);

    typedef enum logic {
        IDLE,
        LOCK
    } state_t;

    state_t                      state, state_nxt;
    logic [IDW-1:0]              rr_ptr, rr_nxt;
    logic [IDW-1:0]              grant_nxt;
    logic [IDW-1:0]              winner;
    logic                        found;
    logic [BCW-1:0]              beat_cnt, beat_nxt;
    logic [SCW-1:0]              stall_cnt, stall_nxt;
    logic                        done_nxt;
    logic                        err_nxt;
    logic                        sel_valid;
    logic                        handshake;
    logic [INPUT_DATA_WIDTH-1:0] words [NUM_REQ];

    // Modulo wrap keeps indices legal when NUM_REQ is not a power of two.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int unsigned ofs);
        return IDW'((32'(base) + ofs) % NUM_REQ);
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign words[g] = req_wdata[g*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH];
    end

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[wrap_add(rr_ptr, i)]) begin
                found  = 1'b1;
                winner = wrap_add(rr_ptr, i);
            end
        end
    end

    assign sel_valid = req_valid[grant_id];
    assign handshake = (state == LOCK) && sel_valid && arb_cmd_ready;
    assign busy      = (state == LOCK);

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant_id;
        rr_nxt        = rr_ptr;
        beat_nxt      = beat_cnt;
        stall_nxt     = '0;
        done_nxt      = 1'b0;
        err_nxt       = stall_err;
        arb_cmd_valid = 1'b0;
        req_ready     = '0;
        arb_cmd_wdata = words[grant_id];

        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = LOCK;
                    grant_nxt = winner;
                    beat_nxt  = '0;
                end
            end
            LOCK: begin
                arb_cmd_valid       = sel_valid;
                req_ready[grant_id] = arb_cmd_ready;
                if (handshake) begin
                    stall_nxt = '0;
                    if (beat_cnt == LAST_BEAT) begin
                        state_nxt = IDLE;
                        beat_nxt  = '0;
                        done_nxt  = 1'b1;
                        rr_nxt    = wrap_add(grant_id, 1);
                    end else begin
                        beat_nxt = beat_cnt + 1'b1;
                    end
                end else if (!sel_valid && stall_cnt != STALL_MAX) begin
                    stall_nxt = stall_cnt + 1'b1;
                end else begin
                    // Downstream backpressure holds the count without advancing it.
                    stall_nxt = stall_cnt;
                end
                if (stall_nxt == STALL_MAX) begin
                    err_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            beat_cnt  <= '0;
            stall_cnt <= '0;
            cmd_done  <= 1'b0;
            stall_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_nxt;
            grant_id  <= grant_nxt;
            beat_cnt  <= beat_nxt;
            stall_cnt <= stall_nxt;
            cmd_done  <= done_nxt;
            stall_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_dwc_cmd_arb.sv
// Directed bench for dwc_cmd_arb: scoreboard of expected (owner, word) beats plus
// cycle-exact checks of grant, completion pulse, backpressure and stall flag.
module tb_dwc_cmd_arb;

    localparam int NR = 4;
    localparam int IW = 32;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*IW-1:0] req_wdata;
    logic            arb_cmd_valid;
    logic            arb_cmd_ready;
    logic [IW-1:0]   arb_cmd_wdata;
    logic [1:0]      grant_id;
    logic            busy;
    logic            cmd_done;
    logic            stall_err;

    dwc_cmd_arb #(
        .NUM_REQ(NR),
        .INPUT_DATA_WIDTH(IW),
        .OUTPUT_DATA_WIDTH(128),
        .STALL_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wdata(req_wdata),
        .arb_cmd_valid(arb_cmd_valid),
        .arb_cmd_ready(arb_cmd_ready),
        .arb_cmd_wdata(arb_cmd_wdata),
        .grant_id(grant_id),
        .busy(busy),
        .cmd_done(cmd_done),
        .stall_err(stall_err)
    );

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   src_seq[NR] = '{default: 0};
    int   exp_seq[NR] = '{default: 0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input int r, input int s);
        return (32'(r) << 24) | (32'hA0 + 32'(s));
    endfunction

    // Requester-side FIFO model: next word is presented after each accepted beat.
    for (genvar g = 0; g < NR; g++) begin : g_src
        assign req_wdata[g*IW +: IW] = word(g, src_seq[g]);
        always @(posedge clk) begin
            if (req_valid[g] && req_ready[g]) src_seq[g] <= src_seq[g] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic push_words(input int r, input int n);
        for (int k = 0; k < n; k++) begin
            sb.push_back('{id: 2'(r), data: word(r, exp_seq[r])});
            exp_seq[r]++;
        end
    endtask

    task automatic reset_dut();
        rst_n         = 1'b0;
        req_valid     = '0;
        arb_cmd_ready = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && arb_cmd_valid && arb_cmd_ready) begin
            n_tests++;
            assert (sb.size() > 0)
            else begin
                n_fail++;
                $error("FAIL sb_underflow: observed beat %0h from %0d expected none", arb_cmd_wdata, grant_id);
            end
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("sb_word", arb_cmd_wdata, mon_e.data);
                chk("sb_owner", 32'(grant_id), 32'(mon_e.id));
                chk("sb_ready_onehot", 32'(req_ready), 32'(1) << mon_e.id);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        req_valid     = '0;
        arb_cmd_ready = 1'b0;
        repeat (2) cyc();
        smp();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(cmd_done), 32'd0);
        chk("rst_err", 32'(stall_err), 32'd0);
        chk("rst_valid", 32'(arb_cmd_valid), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);

        // Single requester 2, ready held high.
        reset_dut();
        req_valid = 4'b0100; arb_cmd_ready = 1'b1; push_words(2, 4);
        smp();
        chk("t1_arb_busy", 32'(busy), 32'd0);
        chk("t1_arb_valid", 32'(arb_cmd_valid), 32'd0);
        cyc(); smp();
        chk("t1_grant", 32'(grant_id), 32'd2);
        chk("t1_busy", 32'(busy), 32'd1);
        repeat (3) cyc();
        cyc(); req_valid = '0; smp();
        chk("t1_done", 32'(cmd_done), 32'd1);
        chk("t1_idle", 32'(busy), 32'd0);
        cyc(); smp();
        chk("t1_done_pulse", 32'(cmd_done), 32'd0);
        // rr_ptr now 3: requester 3 beats requester 0.
        cyc(); req_valid = 4'b1101; push_words(3, 4);
        cyc(); smp();
        chk("t1_rr_grant", 32'(grant_id), 32'd3);
        repeat (3) cyc();
        cyc(); req_valid = '0; smp();
        chk("t1_rr_done", 32'(cmd_done), 32'd1);

        // All requesters valid: order 0,1,2,3,0 with one idle cycle between.
        reset_dut();
        req_valid = 4'b1111; arb_cmd_ready = 1'b1;
        push_words(0, 4); push_words(1, 4); push_words(2, 4); push_words(3, 4); push_words(0, 4);
        for (int k = 0; k < 5; k++) begin
            smp();
            chk("t2_gap", 32'(busy), 32'd0);
            if (k > 0) chk("t2_done", 32'(cmd_done), 32'd1);
            cyc(); smp();
            chk("t2_grant", 32'(grant_id), 32'(k % 4));
            chk("t2_busy", 32'(busy), 32'd1);
            repeat (3) cyc();
            cyc();
        end
        req_valid = '0; smp();
        chk("t2_last_done", 32'(cmd_done), 32'd1);

        // Backpressure on requester 1.
        reset_dut();
        req_valid = 4'b0010; arb_cmd_ready = 1'b0; push_words(1, 4);
        smp();
        chk("t3_arb_busy", 32'(busy), 32'd0);
        cyc(); req_valid = 4'b1011;
        for (int i = 0; i < 7; i++) begin
            arb_cmd_ready = (i % 2 == 0);
            smp();
            chk("t3_ready", 32'(req_ready), (i % 2 == 0) ? 32'h2 : 32'h0);
            chk("t3_busy", 32'(busy), 32'd1);
            cyc();
        end
        req_valid = '0; arb_cmd_ready = 1'b1; smp();
        chk("t3_done", 32'(cmd_done), 32'd1);
        chk("t3_idle", 32'(busy), 32'd0);

        // Requester 0 raises valid mid-command of requester 3.
        reset_dut();
        req_valid = 4'b1000; arb_cmd_ready = 1'b1; push_words(3, 4);
        cyc(); cyc();
        cyc(); req_valid = 4'b1001; push_words(0, 4); smp();
        chk("t4_hold_ready3", 32'(req_ready), 32'h8);
        chk("t4_hold_grant", 32'(grant_id), 32'd3);
        cyc(); smp();
        chk("t4_hold_ready4", 32'(req_ready), 32'h8);
        cyc(); req_valid = 4'b0001; smp();
        chk("t4_done", 32'(cmd_done), 32'd1);
        chk("t4_idle_ready", 32'(req_ready), 32'h0);
        cyc(); smp();
        chk("t4_grant0", 32'(grant_id), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        repeat (3) cyc();
        cyc(); req_valid = '0; smp();
        chk("t4_done0", 32'(cmd_done), 32'd1);

        // Stall with STALL_LIMIT=4.
        reset_dut();
        req_valid = 4'b0001; arb_cmd_ready = 1'b1; push_words(0, 4);
        cyc();
        cyc(); req_valid = '0;
        for (int i = 1; i <= 6; i++) begin
            smp();
            chk("t5_stall_err", 32'(stall_err), 32'(i >= 5));
            chk("t5_valid", 32'(arb_cmd_valid), 32'd0);
            chk("t5_busy", 32'(busy), 32'd1);
            cyc();
        end
        req_valid = 4'b0001; smp();
        chk("t5_err_sticky", 32'(stall_err), 32'd1);
        cyc(); cyc();
        cyc(); req_valid = '0; smp();
        chk("t5_done", 32'(cmd_done), 32'd1);
        chk("t5_err_kept", 32'(stall_err), 32'd1);

        // Reset pulse mid-command (rr_ptr is 1 coming in).
        cyc(); req_valid = 4'b0100; arb_cmd_ready = 1'b1; push_words(2, 2);
        cyc(); cyc();
        cyc(); rst_n = 1'b0; arb_cmd_ready = 1'b0;
        cyc(); rst_n = 1'b1; arb_cmd_ready = 1'b1; req_valid = 4'b0101; push_words(0, 4); smp();
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_no_done", 32'(cmd_done), 32'd0);
        chk("t6_err_clr", 32'(stall_err), 32'd0);
        cyc(); smp();
        chk("t6_grant0", 32'(grant_id), 32'd0);
        chk("t6_busy2", 32'(busy), 32'd1);
        repeat (3) cyc();
        cyc(); req_valid = '0; smp();
        chk("t6_done", 32'(cmd_done), 32'd1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
